wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the RV32I pipeline; sits directly upstream of the register file and drives its rd / rd_en / rd_data write port.
- Accepts one retiring instruction per handshake from the memory stage.
- Selects the result source (ALU, load, PC+4, immediate), then sign/zero-extends and aligns load data.
- Waits for variable-latency load responses, counts retired instructions and flags load faults.

Parameters:
- LOAD_TIMEOUT, 16, max cycles in LOAD_WAIT before a load fault is declared (min 1).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  memory stage presents an instruction
- in_ready  output  1  stage can accept an instruction this cycle
- in_rd  input  5  destination register index
- in_rd_en  input  1  instruction writes rd
- in_sel  input  2  result source: 0=ALU, 1=LOAD, 2=PC+4, 3=IMM
- in_alu  input  32  ALU result / load effective address
- in_pc  input  32  instruction PC
- in_imm  input  32  U-type immediate (LUI)
- in_funct3  input  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_rvalid  input  1  load response valid
- mem_rdata  input  32  raw word-aligned load data
- rd  output  5  register file write index
- rd_en  output  1  register file write enable (one-cycle pulse)
- rd_data  output  32  register file write data
- load_fault  output  1  sticky: misaligned load, illegal funct3 or timeout
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset when reset==0 at posedge clk:
  - state=IDLE
  - rd=0, rd_en=0, rd_data=0
  - load_fault=0, instret=0
  - timeout counter=0
  - in_ready=1 after reset
- Reset mid-LOAD_WAIT abandons the load: no write, no retire.
- States:
  - IDLE: in_ready=1.
  - LOAD_WAIT: in_ready=0.
- Accept rule: accept when in_valid && in_ready.
- Non-load accept (sel 0/2/3):
  - Next cycle: rd=in_rd, rd_en=in_rd_en, rd_data = in_alu / in_pc+4 (mod 2^32) / in_imm.
  - instret increments. Latency 1 cycle. Stays IDLE; back-to-back accepts every cycle allowed.
- Load accept (sel 1):
  - Latch rd, rd_en, funct3, in_alu[1:0]. Go to LOAD_WAIT, clear the timeout counter.
  - Misaligned load (LH/LHU with addr[0]=1, LW with addr[1:0]!=0) or illegal funct3:
    - set load_fault, retire with rd_en=0 next cycle, stay IDLE.
- LOAD_WAIT:
  - mem_rvalid=1 in the same cycle as the load is accepted is ignored; the response is only sampled in LOAD_WAIT.
  - On mem_rvalid:
    - byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
    - Sign- or zero-extend per funct3.
    - Drive rd/rd_en/rd_data next cycle, instret++, return to IDLE.
  - Else the counter increments. When it reaches LOAD_TIMEOUT:
    - set load_fault, retire with rd_en=0, instret++, return to IDLE.
- Register zero: rd_en forced 0 whenever rd==0. x0 is never written by this stage.
- rd_en is 0 in every cycle without a retire. rd and rd_data hold their last value.
- load_fault is sticky until reset.
- instret wraps modulo 2^CNT_W.
- Faulted instructions still count in instret.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds outputs byp_valid (1), byp_rd (5) and byp_data (32).
  - Combinationally mirror the value being written this cycle (byp_valid = rd_en).
  - Lets decode forward same-cycle writebacks around the register file.
- Undefined: ports absent. Consumers see the write one cycle later via the register file.

Test Plan:
- Reset held low 3 cycles with in_valid=1 -> rd_en=0, instret=0, load_fault=0, in_ready=1 after release.
- ALU ops back-to-back: rd=5 val 0x1234, then rd=6 val 0xFFFF0000 on consecutive cycles -> rd_en pulses two cycles, correct data, instret=2.
- Load LB addr[1:0]=3, mem_rdata=0x80AA_BBCC arriving 4 cycles later -> in_ready=0 for 4 cycles, rd_data=0xFFFFFF80. Same with LBU -> 0x00000080.
- LH at addr[1:0]=1 -> load_fault=1, no write, instret++, next instruction accepted the following cycle.
- Load with no mem_rvalid for LOAD_TIMEOUT=16 cycles -> load_fault=1 at cycle 16, returns IDLE, rd_en never asserts.
- Write to rd=0 with in_rd_en=1, sel=PC+4 -> rd_en stays 0, instret increments. Reset asserted during LOAD_WAIT -> IDLE, no write.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Brief    : RV32I writeback stage. Selects the retiring result (ALU, load,
//             PC+4 or immediate), extends and aligns load data, waits for
//             variable-latency load responses, counts retired instructions
//             and raises a sticky load fault.
//  Options  : define WB_BYPASS_EN to add the byp_valid / byp_rd / byp_data
//             same-cycle forwarding outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 64
) (
  input  logic              clk,
  input  logic              reset,
  // memory-stage handshake
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_en,
  input  logic [1:0]        in_sel,
  input  logic [31:0]       in_alu,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_imm,
  input  logic [2:0]        in_funct3,
  // load response
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  // register file write port
  output logic [4:0]        rd,
  output logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              load_fault,
`ifdef WB_BYPASS_EN
  output logic              byp_valid,
  output logic [4:0]        byp_rd,
  output logic [31:0]       byp_data,
`endif
  output logic [CNT_W-1:0]  instret
);

  // Result source selector encoding
  localparam logic [1:0] c_SEL_ALU  = 2'd0;
  localparam logic [1:0] c_SEL_LOAD = 2'd1;
  localparam logic [1:0] c_SEL_PC4  = 2'd2;
  localparam logic [1:0] c_SEL_IMM  = 2'd3;

  // Load funct3 encodings
  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  // Timeout counter sized to hold LOAD_TIMEOUT; the fault fires on the
  // LOAD_TIMEOUT-th consecutive cycle spent waiting without a response.
  localparam int unsigned          c_TCNT_W    = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [c_TCNT_W-1:0]  c_TCNT_LAST = c_TCNT_W'(LOAD_TIMEOUT - 1);
  localparam logic [c_TCNT_W-1:0]  c_TCNT_ONE  = c_TCNT_W'(1);
  localparam logic [CNT_W-1:0]     c_CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_TCNT_W-1:0]   r_tcnt;
  logic [4:0]            r_ld_rd;
  logic                  r_ld_rd_en;
  logic [2:0]            r_ld_funct3;
  logic [1:0]            r_ld_addr;

  logic                  w_accept;
  logic                  w_is_load;
  logic                  w_load_ok;
  logic [31:0]           w_simple_data;
  logic [31:0]           w_load_data;

  // Legal funct3 with a naturally aligned address
  function automatic logic f_load_ok(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      c_F3_LB, c_F3_LBU: ok = 1'b1;
      c_F3_LH, c_F3_LHU: ok = ~a[0];
      c_F3_LW:           ok = (a == 2'b00);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Pick the addressed byte/half out of the word and extend it
  function automatic logic [31:0] f_load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  a,
                                                input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      c_F3_LB:  res = {{24{b[7]}}, b};
      c_F3_LH:  res = {{16{h[15]}}, h};
      c_F3_LBU: res = {24'd0, b};
      c_F3_LHU: res = {16'd0, h};
      default:  res = w;
    endcase
    return res;
  endfunction

  assign w_accept    = in_valid & in_ready;
  assign w_is_load   = (in_sel == c_SEL_LOAD);
  assign w_load_ok   = f_load_ok(in_funct3, in_alu[1:0]);
  assign w_load_data = f_load_extend(r_ld_funct3, r_ld_addr, mem_rdata);

  // Result mux for the single-cycle (non-load) sources
  always_comb begin
    w_simple_data = in_alu;
    case (in_sel)
      c_SEL_ALU: w_simple_data = in_alu;
      c_SEL_PC4: w_simple_data = in_pc + 32'd4;
      c_SEL_IMM: w_simple_data = in_imm;
      default:   w_simple_data = in_alu;
    endcase
  end

  // Writeback FSM: accepts, load wait/timeout, retire count, register outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      in_ready    <= 1'b1;
      rd          <= 5'd0;
      rd_en       <= 1'b0;
      rd_data     <= 32'd0;
      load_fault  <= 1'b0;
      instret     <= '0;
      r_tcnt      <= '0;
      r_ld_rd     <= 5'd0;
      r_ld_rd_en  <= 1'b0;
      r_ld_funct3 <= 3'd0;
      r_ld_addr   <= 2'd0;
    end else begin
      // write enable is a single-cycle pulse
      rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_is_load) begin
              rd      <= in_rd;
              rd_en   <= in_rd_en & (in_rd != 5'd0);
              rd_data <= w_simple_data;
              instret <= instret + c_CNT_ONE;
            end else if (!w_load_ok) begin
              // bad load retires immediately without a write
              load_fault <= 1'b1;
              instret    <= instret + c_CNT_ONE;
            end else begin
              r_ld_rd     <= in_rd;
              r_ld_rd_en  <= in_rd_en;
              r_ld_funct3 <= in_funct3;
              r_ld_addr   <= in_alu[1:0];
              r_tcnt      <= '0;
              r_state     <= ST_LOAD_WAIT;
              in_ready    <= 1'b0;
            end
          end
        end
        ST_LOAD_WAIT: begin
          if (mem_rvalid) begin
            rd       <= r_ld_rd;
            rd_en    <= r_ld_rd_en & (r_ld_rd != 5'd0);
            rd_data  <= w_load_data;
            instret  <= instret + c_CNT_ONE;
            r_state  <= ST_IDLE;
            in_ready <= 1'b1;
          end else if (r_tcnt == c_TCNT_LAST) begin
            load_fault <= 1'b1;
            instret    <= instret + c_CNT_ONE;
            r_tcnt     <= '0;
            r_state    <= ST_IDLE;
            in_ready   <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + c_TCNT_ONE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Mirror the write currently presented to the register file
  always_comb begin
    byp_valid = rd_en;
    byp_rd    = rd;
    byp_data  = rd_data;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Brief    : Scoreboard bench for wb_stage. Expected register writes are
//             queued at issue time; a monitor pops one entry per rd_en pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_en;
  logic [1:0]  in_sel;
  logic [31:0] in_alu;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        load_fault;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;
  logic [36:0] sb[$];

  wb_stage #(.LOAD_TIMEOUT(16), .CNT_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_rd_en   (in_rd_en),
    .in_sel     (in_sel),
    .in_alu     (in_alu),
    .in_pc      (in_pc),
    .in_imm     (in_imm),
    .in_funct3  (in_funct3),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rd         (rd),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .load_fault (load_fault),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {27'd0, rd, rd_data}, 64'd0);
        end else begin
          logic [36:0] e;
          e = sb.pop_front();
          chk("write_rd_data", {27'd0, rd, rd_data}, {27'd0, e});
        end
      end
    end
  end

  // Drive one instruction; leaves in_valid high so callers can chain
  task automatic issue(input logic [1:0] sel, input logic [4:0] r, input logic en,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [2:0] f3);
    chk("issue_ready", {63'd0, in_ready}, 64'd1);
    in_valid  = 1'b1;
    in_sel    = sel;
    in_rd     = r;
    in_rd_en  = en;
    in_alu    = alu;
    in_pc     = pc;
    in_imm    = imm;
    in_funct3 = f3;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Aligned load whose response arrives in the lat-th waiting cycle
  task automatic run_load(input logic [4:0] r, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int lat, input logic [31:0] exp);
    int low;
    low = 0;
    sb.push_back({r, exp});
    mem_rvalid = 1'b1;          // same-cycle response must be ignored
    mem_rdata  = ~data;
    issue(2'd1, r, 1'b1, addr, 32'h0, 32'h0, f3);
    idle();
    mem_rvalid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (i == lat - 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data;
      end
      @(negedge clk);
      if (in_ready === 1'b0) low++;
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("load_wait_cycles", 64'(low), 64'(lat));
    chk("load_ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    reset = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_rd = 5'd7; in_rd_en = 1'b1;
    in_alu = 32'h1111; in_pc = 32'h0; in_imm = 32'h0; in_funct3 = 3'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_load_fault", {63'd0, load_fault}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // back-to-back ALU results
    sb.push_back({5'd5, 32'h0000_1234});
    issue(2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 3'd0);
    sb.push_back({5'd6, 32'hFFFF_0000});
    issue(2'd0, 5'd6, 1'b1, 32'hFFFF_0000, 32'h0, 32'h0, 3'd0);
    idle();
    @(negedge clk);
    chk("alu_instret", instret, 64'd2);
    @(posedge clk); #1;

    // loads: byte at offset 3 signed/unsigned, half at offset 2, word
    run_load(5'd10, 3'b000, 32'h0000_1003, 32'h80AA_BBCC, 4, 32'hFFFF_FF80);
    run_load(5'd11, 3'b100, 32'h0000_1003, 32'h80AA_BBCC, 4, 32'h0000_0080);
    run_load(5'd16, 3'b001, 32'h0000_2002, 32'h80AA_BBCC, 1, 32'hFFFF_80AA);
    run_load(5'd17, 3'b010, 32'h0000_2000, 32'h1234_5678, 2, 32'h1234_5678);
    chk("loads_instret", instret, 64'd6);
    chk("loads_no_fault", {63'd0, load_fault}, 64'd0);
    @(posedge clk); #1;

    // misaligned LH faults, next instruction taken the following cycle
    issue(2'd1, 5'd12, 1'b1, 32'h0000_2001, 32'h0, 32'h0, 3'b001);
    sb.push_back({5'd13, 32'h0000_CAFE});
    issue(2'd0, 5'd13, 1'b1, 32'h0000_CAFE, 32'h0, 32'h0, 3'd0);
    idle();
    @(negedge clk);
    chk("misalign_fault", {63'd0, load_fault}, 64'd1);
    chk("misalign_instret", instret, 64'd8);
    @(posedge clk); #1;

    // x0 never written; PC+4 wraps; immediate path
    issue(2'd2, 5'd0, 1'b1, 32'h0, 32'h0000_0100, 32'h0, 3'd0);
    sb.push_back({5'd18, 32'h0000_0000});
    issue(2'd2, 5'd18, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0);
    sb.push_back({5'd19, 32'hABCD_E000});
    issue(2'd3, 5'd19, 1'b1, 32'h0, 32'h0, 32'hABCD_E000, 3'd0);
    idle();
    @(negedge clk);
    chk("misc_instret", instret, 64'd11);
    @(posedge clk); #1;

    // reset during LOAD_WAIT abandons the load
    issue(2'd1, 5'd14, 1'b1, 32'h0000_3000, 32'h0, 32'h0, 3'b010);
    idle();
    @(posedge clk); #1;
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    @(posedge clk); #1;
    reset = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_instret", instret, 64'd0);
    chk("midrst_fault", {63'd0, load_fault}, 64'd0);
    @(posedge clk); #1;

    // no response: timeout after 16 waiting cycles
    issue(2'd1, 5'd15, 1'b1, 32'h0000_4000, 32'h0, 32'h0, 3'b010);
    idle();
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      low++;
      @(posedge clk); #1;
    end
    chk("timeout_cycles", 64'(low), 64'd16);
    chk("timeout_fault", {63'd0, load_fault}, 64'd1);
    chk("timeout_instret", instret, 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
